// File: rtl/onehot_req_arbiter.sv
// Debounced rising edges on four request lines queued as pending events and granted round-robin as a registered one-hot word.
// Raw rise to pend is 2+DEB_CYCLES+1 cycles, then +1 to valid; valid holds until ack, with one idle cycle between grants.
module onehot_req_arbiter #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       ack,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       valid,
  output logic [3:0] pend
);

  typedef enum logic {IDLE, HOLD} state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [3:0]            sync1_q, sync1_d;
  logic [3:0]            sync2_q, sync2_d;
  logic [3:0]            deb_q, deb_d;
  logic [3:0]            deb_prev_q, deb_prev_d;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]            pend_q, pend_d;
  logic [3:0]            onehot_q, onehot_d;
  logic [1:0]            grant_q, grant_d;
  logic [1:0]            ptr_q, ptr_d;
  state_e                state_q, state_d;

  logic [3:0] rise;
  logic [3:0] clr;
  logic       found;
  logic [1:0] pick;
  logic [1:0] idx;

  always_comb begin
    sync1_d    = req;
    sync2_d    = sync1_q;
    deb_prev_d = deb_q;
    deb_d      = deb_q;
    cnt_d      = '0;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Search starts at the round-robin pointer and wraps 3 -> 0.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    idx   = ptr_q;
    for (int j = 0; j < 4; j++) begin
      idx = ptr_q + 2'(j);
      if (!found && pend_q[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    onehot_d = onehot_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    clr      = '0;
    rise     = deb_q & ~deb_prev_q;
    case (state_q)
      IDLE: begin
        onehot_d = '0;
        if (found) begin
          state_d  = HOLD;
          grant_d  = pick;
          onehot_d = 4'b0001 << pick;
        end
      end
      HOLD: begin
        if (ack) begin
          state_d  = IDLE;
          onehot_d = '0;
          clr      = 4'b0001 << grant_q;
          ptr_d    = grant_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new edge landing on the clearing cycle must survive, so set overrides clear.
    pend_d = (pend_q & ~clr) | rise;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      cnt_q      <= '0;
      pend_q     <= '0;
      onehot_q   <= '0;
      grant_q    <= '0;
      ptr_q      <= '0;
      state_q    <= IDLE;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      onehot_q   <= onehot_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      state_q    <= state_d;
    end
  end

  assign a     = onehot_q[0];
  assign b     = onehot_q[1];
  assign c     = onehot_q[2];
  assign d     = onehot_q[3];
  assign valid = (state_q == HOLD);
  assign pend  = pend_q;

endmodule

// File: tb/tb_onehot_req_arbiter.sv
// Bench for onehot_req_arbiter: directed scenarios plus random request/ack traffic,
// compared every cycle against a sample-window model of debounce and round-robin grant.
module tb_onehot_req_arbiter;
  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       ack;
  logic       a, b, c, d, valid;
  logic [3:0] pend;

  always #5 clk = ~clk;

  onehot_req_arbiter #(.DEB_CYCLES(DEB), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack),
    .a(a), .b(b), .c(c), .d(d), .valid(valid), .pend(pend)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: debounced level flips once the last DEB synchronised samples all disagree with it.
  logic [3:0] hist[$];
  logic [3:0] m_deb, m_rise, m_pend;
  logic       m_valid;
  int         m_k, m_ptr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < DEB + 2; i++) hist.push_back(4'd0);
    m_deb = '0; m_rise = '0; m_pend = '0; m_valid = 1'b0; m_k = 0; m_ptr = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic ak);
    logic [3:0] clr, rises, s;
    bit all_diff;
    clr = '0;
    if (m_valid && ak) begin
      clr[m_k] = 1'b1;
      m_valid  = 1'b0;
      m_ptr    = (m_k + 1) % 4;
    end else if (!m_valid && m_pend != 4'd0) begin
      for (int j = 0; j < 4; j++) begin
        if (m_pend[(m_ptr + j) % 4]) begin
          m_k = (m_ptr + j) % 4;
          m_valid = 1'b1;
          break;
        end
      end
    end
    m_pend = (m_pend & ~clr) | m_rise;
    hist.push_front(r);
    rises = '0;
    for (int i = 0; i < 4; i++) begin
      all_diff = 1'b1;
      for (int j = 0; j < DEB; j++) begin
        s = hist[2 + j];
        if (s[i] == m_deb[i]) all_diff = 1'b0;
      end
      if (all_diff) begin
        m_deb[i] = ~m_deb[i];
        rises[i] = m_deb[i];
      end
    end
    m_rise = rises;
    void'(hist.pop_back());
  endtask

  function automatic logic [3:0] m_onehot();
    return m_valid ? 4'(1 << m_k) : 4'd0;
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step(req, ack);
    #1;
    check_eq("onehot", {28'd0, d, c, b, a}, {28'd0, m_onehot()});
    check_eq("valid", {31'd0, valid}, {31'd0, m_valid});
    check_eq("pend", {28'd0, pend}, {28'd0, m_pend});
  endtask

  // Called at posedge+1: asserts reset mid-cycle, checks outputs drop at once, releases mid-cycle.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check_eq("rst_onehot", {28'd0, d, c, b, a}, 32'd0);
    check_eq("rst_valid", {31'd0, valid}, 32'd0);
    check_eq("rst_pend", {28'd0, pend}, 32'd0);
    repeat (2) @(posedge clk);
    #4 rst = 1'b0;
    model_reset();
  endtask

  task automatic wait_grant(output logic [3:0] g);
    g = '0;
    for (int n = 0; n < 30; n++) begin
      if (valid) begin
        g = {d, c, b, a};
        break;
      end
      cycle();
    end
  endtask

  logic [3:0] g;
  logic [3:0] got_q[$];
  logic [3:0] ord3 [4];
  int         first_n;
  bit         seen;
  int         hold_cnt [4];

  initial begin
    rst = 1'b1; req = '0; ack = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("init_onehot", {28'd0, d, c, b, a}, 32'd0);
    check_eq("init_valid", {31'd0, valid}, 32'd0);
    check_eq("init_pend", {28'd0, pend}, 32'd0);
    #3 rst = 1'b0;

    // Single line: pend after 7 edges, grant on the 8th, one-cycle ack.
    req = 4'b0001;
    for (int n = 1; n <= 8; n++) begin
      cycle();
      if (n == 6) check_eq("t1_pend_c6", {28'd0, pend}, 32'h0);
      if (n == 7) check_eq("t1_pend_c7", {28'd0, pend}, 32'h1);
    end
    check_eq("t1_grant", {28'd0, d, c, b, a}, 32'h1);
    check_eq("t1_valid", {31'd0, valid}, 32'd1);
    ack = 1'b1; cycle(); ack = 1'b0;
    check_eq("t1_after_ack_valid", {31'd0, valid}, 32'd0);
    check_eq("t1_after_ack_pend", {28'd0, pend}, 32'd0);
    req = '0;
    repeat (8) cycle();

    // Short glitch is filtered; ack while idle is ignored.
    seen = 1'b0;
    req = 4'b0100; ack = 1'b1;
    repeat (3) begin cycle(); seen |= valid | (pend != 4'd0); end
    req = '0;
    repeat (10) begin cycle(); seen |= valid | (pend != 4'd0); end
    ack = 1'b0;
    check_eq("t2_glitch_seen", {31'd0, seen}, 32'd0);

    // All four rise together from ptr=0: order a,b,c,d.
    do_reset();
    req = 4'b1111;
    got_q.delete();
    for (int n = 0; n < 60 && got_q.size() < 4; n++) begin
      cycle();
      if (valid) got_q.push_back({d, c, b, a});
      ack = valid;
    end
    check_eq("t3_ngrants", got_q.size(), 32'd4);
    ord3 = '{4'h1, 4'h2, 4'h4, 4'h8};
    for (int i = 0; i < got_q.size() && i < 4; i++) check_eq("t3_order", {28'd0, got_q[i]}, {28'd0, ord3[i]});
    cycle(); ack = 1'b0;
    check_eq("t3_pend_empty", {28'd0, pend}, 32'd0);
    req = '0;
    repeat (8) cycle();

    // Move ptr to 3 via a grant on c, then pend=1001 grants d before a; ptr then 1.
    req = 4'b0100;
    wait_grant(g); check_eq("t4_c", {28'd0, g}, 32'h4);
    ack = 1'b1; cycle(); ack = 1'b0;
    req = 4'b1001;
    wait_grant(g); check_eq("t4_d_first", {28'd0, g}, 32'h8);
    ack = 1'b1; cycle(); ack = 1'b0;
    wait_grant(g); check_eq("t4_a_second", {28'd0, g}, 32'h1);
    ack = 1'b1; cycle(); ack = 1'b0;
    req = 4'b0110;
    wait_grant(g); check_eq("t4_ptr1_b", {28'd0, g}, 32'h2);
    ack = 1'b1; cycle(); ack = 1'b0;
    wait_grant(g); check_eq("t4_ptr1_c", {28'd0, g}, 32'h4);
    ack = 1'b1; cycle(); ack = 1'b0;
    req = '0;
    repeat (8) cycle();

    // Long hold on b, then a new edge coinciding with ack keeps pend[1].
    req = 4'b0010;
    wait_grant(g); check_eq("t5_b", {28'd0, g}, 32'h2);
    repeat (20) begin cycle(); check_eq("t5_hold", {28'd0, d, c, b, a}, 32'h2); end
    req = '0;
    repeat (10) cycle();
    req = 4'b0010;
    repeat (6) cycle();
    ack = 1'b1; cycle(); ack = 1'b0;
    check_eq("t5_idle_valid", {31'd0, valid}, 32'd0);
    check_eq("t5_pend_kept", {28'd0, pend}, 32'h2);
    cycle();
    check_eq("t5_regrant", {28'd0, d, c, b, a}, 32'h2);
    check_eq("t5_regrant_valid", {31'd0, valid}, 32'd1);
    ack = 1'b1; cycle(); ack = 1'b0;
    check_eq("t5_cleared", {28'd0, pend}, 32'd0);
    req = '0;
    repeat (8) cycle();

    // Reset mid-HOLD with req[3] held: fresh event 2+DEB+2 edges after release.
    req = 4'b1000;
    wait_grant(g); check_eq("t6_d", {28'd0, g}, 32'h8);
    do_reset();
    first_n = 0;
    for (int n = 1; n <= 20; n++) begin
      cycle();
      if (valid && first_n == 0) first_n = n;
    end
    check_eq("t6_latency", first_n, 32'(2 + DEB + 2));
    check_eq("t6_d_again", {28'd0, d, c, b, a}, 32'h8);
    ack = 1'b1; cycle(); ack = 1'b0;
    req = '0;
    repeat (8) cycle();

    // Random traffic with per-line hold lengths around the debounce window.
    for (int i = 0; i < 4; i++) hold_cnt[i] = 1;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        hold_cnt[i]--;
        if (hold_cnt[i] <= 0) begin
          if ($urandom_range(0, 1) == 1) req[i] = ~req[i];
          hold_cnt[i] = $urandom_range(1, 10);
        end
      end
      ack = ($urandom_range(0, 2) == 0);
      if (n == 1500) do_reset();
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
